// File: rtl/game_status_keeper_pkg.sv
// Shared definitions for the game status keeper: state encoding, display
// limits and a BCD digit helper.
package game_status_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    // LED bar length; HP can never exceed this.
    localparam int HP_BAR_LEN = 16;
    // Width able to hold 0..HP_BAR_LEN.
    localparam int HP_WIDTH = $clog2(HP_BAR_LEN + 1);

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

    localparam logic [6:0] SCORE_BIN_MAX = 7'd127;

    // Single BCD digit increment with wrap 9 -> 0.
    function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/game_status_keeper_bcd_counter.sv
// Four-digit BCD score register with clear, increment and saturation at 9999.
module game_bcd_counter
    import game_status_keeper_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] bcd
);

    logic [15:0]           bcd_reg;
    logic [15:0]           bcd_next;
    logic [BCD_DIGITS-1:0] carry;

    // Counting stops completely once the register shows 9999.
    assign carry[0] = inc && (bcd_reg != BCD_MAX);

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            // A digit ripples into the next one only when it wraps from 9.
            if (gi < BCD_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] && (bcd_reg[gi*4 +: 4] == 4'd9);
            end
            assign bcd_next[gi*4 +: 4] = clr      ? 4'd0 :
                                         carry[gi] ? bcd_digit_inc(bcd_reg[gi*4 +: 4]) :
                                                     bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Score register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
        end else begin
            bcd_reg <= bcd_next;
        end
    end

    assign bcd = bcd_reg;

endmodule

// File: rtl/game_status_keeper.sv
// Per-mode game state keeper: IDLE/RUN/OVER flow, HP with invulnerability
// window after each accepted hit, and the score in BCD and binary form.
module game_status_keeper
    import game_status_keeper_pkg::*;
#(
    parameter int HP_INIT       = 16,
    parameter int HP_MAX        = 16,
    parameter int INVULN_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        hit,
    input  logic        heal,
    input  logic        kill,
    output logic        enable_game,
    output logic [15:0] hp_count,
    output logic [15:0] score_bcd,
    output logic [6:0]  score_bin,
    output logic        game_over
);

    localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);
    localparam logic [HP_WIDTH-1:0] HP_INIT_V = HP_WIDTH'(HP_INIT);
    localparam logic [HP_WIDTH-1:0] HP_MAX_V  = HP_WIDTH'(HP_MAX);

    game_state_t          state_reg, state_next;
    logic [HP_WIDTH-1:0]  hp_reg, hp_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [6:0]           score_bin_reg, score_bin_next;
    logic                 game_over_reg, game_over_next;
    logic                 enable_reg, enable_next;
    logic                 bcd_clr;
    logic                 bcd_inc;
    logic                 hit_accept;

    // Next-state, HP, timer and score logic; abort outranks start, and start
    // outranks every in-game event of the same cycle.
    always_comb begin
        state_next     = state_reg;
        hp_next        = hp_reg;
        timer_next     = timer_reg;
        score_bin_next = score_bin_reg;
        game_over_next = 1'b0;
        bcd_clr        = 1'b0;
        bcd_inc        = 1'b0;
        hit_accept     = 1'b0;

        if (abort) begin
            state_next     = ST_IDLE;
            hp_next        = '0;
            timer_next     = '0;
            score_bin_next = '0;
            bcd_clr        = 1'b1;
        end else if (start) begin
            state_next     = ST_RUN;
            hp_next        = HP_INIT_V;
            timer_next     = '0;
            score_bin_next = '0;
            bcd_clr        = 1'b1;
        end else if (state_reg == ST_RUN) begin
            hit_accept = hit && (timer_reg == '0);

            if (hit_accept) begin
                timer_next = TIMER_LOAD;
            end else if (timer_reg != '0) begin
                timer_next = timer_reg - 1'b1;
            end

            // A heal cancels an accepted hit; an ignored hit lets the heal through.
            if (hit_accept && !heal) begin
                if (hp_reg != '0) begin
                    hp_next = hp_reg - 1'b1;
                end
            end else if (!hit_accept && heal) begin
                if (hp_reg < HP_MAX_V) begin
                    hp_next = hp_reg + 1'b1;
                end
            end

            // Kills still count on the cycle of the fatal hit.
            if (kill) begin
                bcd_inc = 1'b1;
                if (score_bin_reg != SCORE_BIN_MAX) begin
                    score_bin_next = score_bin_reg + 7'd1;
                end
            end

            if (hp_next == '0) begin
                state_next     = ST_OVER;
                game_over_next = 1'b1;
            end
        end

        enable_next = (state_next == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            hp_reg        <= '0;
            timer_reg     <= '0;
            score_bin_reg <= '0;
            game_over_reg <= 1'b0;
            enable_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hp_reg        <= hp_next;
            timer_reg     <= timer_next;
            score_bin_reg <= score_bin_next;
            game_over_reg <= game_over_next;
            enable_reg    <= enable_next;
        end
    end

    game_bcd_counter u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bcd_clr),
        .inc   (bcd_inc),
        .bcd   (score_bcd)
    );

    assign enable_game = enable_reg;
    assign hp_count    = {{(16-HP_WIDTH){1'b0}}, hp_reg};
    assign score_bin   = score_bin_reg;
    assign game_over   = game_over_reg;

endmodule

// File: tb/tb_game_status_keeper.sv
// Self-checking bench: directed and random event stimulus, a behavioural
// game model producing expected outputs into a queue, and a monitor that
// compares them against the DUT every cycle.
module tb_game_status_keeper;

    localparam int INV = 4;
    localparam int HPI = 16;
    localparam int HPM = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, hit = 1'b0, heal = 1'b0, kill = 1'b0;
    logic        enable_game;
    logic [15:0] hp_count;
    logic [15:0] score_bcd;
    logic [6:0]  score_bin;
    logic        game_over;

    game_status_keeper #(
        .HP_INIT       (HPI),
        .HP_MAX        (HPM),
        .INVULN_CYCLES (INV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .hit         (hit),
        .heal        (heal),
        .kill        (kill),
        .enable_game (enable_game),
        .hp_count    (hp_count),
        .score_bcd   (score_bcd),
        .score_bin   (score_bin),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int hp;
        int bcd;
        int bin;
        int go;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    // Reference model: plain integer game rules.
    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
    int m_state = M_IDLE;
    int m_hp    = 0;
    int m_score = 0;
    int m_wait  = 0;   // remaining cycles of invulnerability
    int m_go    = 0;

    function automatic int to_bcd(input int score);
        int s;
        s = (score > 9999) ? 9999 : score;
        return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
    endfunction

    function automatic void check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_passed++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_hp = 0; m_score = 0; m_wait = 0; m_go = 0;
    endtask

    task automatic model_step(input bit rst_low, input bit s, input bit a,
                              input bit h, input bit he, input bit k);
        bit took;
        m_go = 0;
        if (rst_low) begin
            model_reset();
        end else if (a) begin
            m_state = M_IDLE; m_hp = 0; m_score = 0; m_wait = 0;
        end else if (s) begin
            m_state = M_RUN; m_hp = HPI; m_score = 0; m_wait = 0;
        end else if (m_state == M_RUN) begin
            took = h && (m_wait == 0);
            if (took) m_wait = INV - 1;
            else if (m_wait > 0) m_wait--;
            if (took && !he) m_hp = (m_hp > 0) ? m_hp - 1 : 0;
            else if (!took && he) m_hp = (m_hp < HPM) ? m_hp + 1 : HPM;
            if (k) m_score++;
            if (m_hp == 0) begin
                m_state = M_OVER;
                m_go = 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.en  = (m_state == M_RUN) ? 1 : 0;
        e.hp  = m_hp;
        e.bcd = to_bcd(m_score);
        e.bin = (m_score > 127) ? 127 : m_score;
        e.go  = m_go;
        return e;
    endfunction

    // One clock of stimulus: apply inputs, let the edge sample them, queue expectation.
    task automatic drive(input bit s, input bit a, input bit h, input bit he, input bit k);
        start = s; abort = a; hit = h; heal = he; kill = k;
        @(posedge clk);
        model_step(!rst_n, s, a, h, he, k);
        exp_q.push_back(model_out());
        #1;
        start = 0; abort = 0; hit = 0; heal = 0; kill = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle presents a full output set to compare.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("enable_game", int'(enable_game), e.en);
            check("hp_count",    int'(hp_count),    e.hp);
            check("score_bcd",   int'(score_bcd),   e.bcd);
            check("score_bin",   int'(score_bin),   e.bin);
            check("game_over",   int'(game_over),   e.go);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then release between edges.
        idle(2);
        @(negedge clk); #2; rst_n = 1'b1;
        idle(2);

        // Start and 12 kills.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1);

        // Drive the score to 9998, then three more kills saturate at 9999.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 9998; i++) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);

        // Invulnerability window: back-to-back hits count once, hit 4 cycles later counts.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(4);
        drive(0, 0, 1, 1, 0);      // accepted hit + heal at 14 -> 14
        drive(0, 0, 1, 1, 0);      // ignored hit + heal -> 15
        idle(4);
        drive(0, 0, 0, 1, 0);      // 16
        drive(0, 0, 0, 1, 0);      // saturated at 16

        // Spaced hits down to zero; kill on the fatal hit still counts.
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 0, (i == 15));
            idle(INV - 1);
        end
        drive(0, 0, 1, 0, 1);      // ignored in OVER
        drive(0, 0, 0, 1, 0);
        idle(2);

        // Restart from OVER, then abort beats start.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0);
        idle(2);

        // Asynchronous reset in the middle of a game.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk); #2; rst_n = 1'b0;
        #1;
        check("async_rst_enable", int'(enable_game), 0);
        check("async_rst_hp",     int'(hp_count),    0);
        check("async_rst_bcd",    int'(score_bcd),   0);
        check("async_rst_bin",    int'(score_bin),   0);
        model_reset();
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        @(negedge clk); #2; rst_n = 1'b1;
        drive(0, 0, 1, 1, 1);      // IDLE after release: events ignored
        idle(2);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 1),
                  ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 40));
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
